pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core (IF, ID, EX, ME, WB).
- Drives the per-stage advance and flush controls of every pipeline register, including the ME-stage register.
- Resolves three hazard types:
  - load-use hazards, by inserting a bubble;
  - taken branches, by squashing younger instructions;
  - multi-cycle data-memory accesses, by freezing the pipe.
- Holds a watchdog on memory waits and counts stall and flush events for debug.

---
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencer and the five-stage datapath.
// master = sequencer side, slave = datapath side.
interface pipe_ctrl_if #(
  parameter int unsigned REG_IDX_W  = 5,
  parameter int unsigned DEST_SRC_W = 2,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_IDX_W-1:0]  i_id_rs1;
  logic [REG_IDX_W-1:0]  i_id_rs2;
  logic                  i_id_rs1_used;
  logic                  i_id_rs2_used;
  logic [DEST_SRC_W-1:0] i_ex_dest_src;
  logic [REG_IDX_W-1:0]  i_ex_dest_reg;
  logic                  i_ex_branch_taken;
  logic                  i_me_mem_req;
  logic                  i_dmem_ack;

  logic                  o_pc_adv;
  logic                  o_ifid_adv;
  logic                  o_idex_adv;
  logic                  o_exme_adv;
  logic                  o_mewb_adv;
  logic                  o_ifid_flush;
  logic                  o_idex_flush;
  logic                  o_exme_flush;
  logic                  o_mewb_flush;
  logic                  o_dmem_req;
  logic                  o_mem_err;
  logic [CNT_W-1:0]      o_stall_cnt;
  logic [CNT_W-1:0]      o_flush_cnt;

  modport master (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_dest_src, i_ex_dest_reg, i_ex_branch_taken,
           i_me_mem_req, i_dmem_ack,
    output o_pc_adv, o_ifid_adv, o_idex_adv, o_exme_adv, o_mewb_adv,
           o_ifid_flush, o_idex_flush, o_exme_flush, o_mewb_flush,
           o_dmem_req, o_mem_err, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_dest_src, i_ex_dest_reg, i_ex_branch_taken,
           i_me_mem_req, i_dmem_ack,
    input  o_pc_adv, o_ifid_adv, o_idex_adv, o_exme_adv, o_mewb_adv,
           o_ifid_flush, o_idex_flush, o_exme_flush, o_mewb_flush,
           o_dmem_req, o_mem_err, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: load-use bubbles, branch squash, memory-wait
// freeze with watchdog, and saturating stall/flush debug counters.
module pipe_ctrl #(
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned DEST_SRC_W   = 2,
  parameter int unsigned DEST_SRC_MEM = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        clr,
  pipe_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last wait count from which a further miss trips the watchdog.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_q, flush_cnt_q;

  logic load_use;
  logic do_adv;
  logic branch_evt;
  logic pc_adv, ifid_adv, idex_adv, exme_adv, mewb_adv;
  logic ifid_flush, idex_flush, exme_flush, mewb_flush;
  logic dmem_req;
  logic stall_evt;

  // EX holds a load whose destination the ID instruction reads.
  assign load_use = (bus.i_ex_dest_src == DEST_SRC_W'(DEST_SRC_MEM)) &&
                    (bus.i_ex_dest_reg != '0) &&
                    ((bus.i_id_rs1_used && (bus.i_id_rs1 == bus.i_ex_dest_reg)) ||
                     (bus.i_id_rs2_used && (bus.i_id_rs2 == bus.i_ex_dest_reg)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_INIT;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (branch_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    do_adv     = 1'b0;
    branch_evt = 1'b0;
    pc_adv     = 1'b0;
    ifid_adv   = 1'b0;
    idex_adv   = 1'b0;
    exme_adv   = 1'b0;
    mewb_adv   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exme_flush = 1'b0;
    mewb_flush = 1'b0;
    dmem_req   = 1'b0;

    case (state_q)
      S_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exme_flush = 1'b1;
        mewb_flush = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        dmem_req = bus.i_me_mem_req;
        if (bus.i_me_mem_req && !bus.i_dmem_ack) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          do_adv = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (bus.i_dmem_ack) begin
          state_d = S_RUN;
          wait_d  = '0;
          do_adv  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q >= WAIT_LAST) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Advance rules shared by RUN and the MEM_WAIT ack cycle.
    if (do_adv) begin
      if (bus.i_ex_branch_taken) begin
        {pc_adv, ifid_adv, idex_adv, exme_adv, mewb_adv} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        branch_evt = 1'b1;
      end else if (load_use) begin
        idex_adv   = 1'b1;
        idex_flush = 1'b1;
        exme_adv   = 1'b1;
        mewb_adv   = 1'b1;
      end else begin
        {pc_adv, ifid_adv, idex_adv, exme_adv, mewb_adv} = 5'b11111;
      end
    end
  end

  assign stall_evt = (state_q != S_INIT) && !pc_adv;

  assign bus.o_pc_adv     = pc_adv;
  assign bus.o_ifid_adv   = ifid_adv;
  assign bus.o_idex_adv   = idex_adv;
  assign bus.o_exme_adv   = exme_adv;
  assign bus.o_mewb_adv   = mewb_adv;
  assign bus.o_ifid_flush = ifid_flush;
  assign bus.o_idex_flush = idex_flush;
  assign bus.o_exme_flush = exme_flush;
  assign bus.o_mewb_flush = mewb_flush;
  assign bus.o_dmem_req   = dmem_req;
  assign bus.o_mem_err    = err_q;
  assign bus.o_stall_cnt  = stall_q;
  assign bus.o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, memory wait, watchdog, reset and
// counter saturation (second instance with 4-bit counters).
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_IDX_W(5), .DEST_SRC_W(2), .CNT_W(16)) bus ();
  pipe_ctrl_if #(.REG_IDX_W(5), .DEST_SRC_W(2), .CNT_W(4))  bus_s ();

  pipe_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .clr(clr), .bus(bus));
  pipe_ctrl #(.CNT_W(4))  u_sat (.clk(clk), .clr(clr), .bus(bus_s));

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] adv_m;
  logic [3:0] fl_m;
  assign adv_m = {bus.o_pc_adv, bus.o_ifid_adv, bus.o_idex_adv, bus.o_exme_adv, bus.o_mewb_adv};
  assign fl_m  = {bus.o_ifid_flush, bus.o_idex_flush, bus.o_exme_flush, bus.o_mewb_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rs1, input int rs1_used, input int rs2, input int rs2_used,
                       input int dsrc, input int dreg, input int br, input int mreq, input int ack);
    bus.i_id_rs1          = 5'(rs1);
    bus.i_id_rs1_used     = 1'(rs1_used);
    bus.i_id_rs2          = 5'(rs2);
    bus.i_id_rs2_used     = 1'(rs2_used);
    bus.i_ex_dest_src     = 2'(dsrc);
    bus.i_ex_dest_reg     = 5'(dreg);
    bus.i_ex_branch_taken = 1'(br);
    bus.i_me_mem_req      = 1'(mreq);
    bus.i_dmem_ack        = 1'(ack);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Load-use on the saturation instance when on=1, idle otherwise.
  task automatic drive_s(input int on);
    bus_s.i_id_rs1          = 5'd0;
    bus_s.i_id_rs1_used     = 1'b0;
    bus_s.i_id_rs2          = (on != 0) ? 5'd5 : 5'd0;
    bus_s.i_id_rs2_used     = 1'(on);
    bus_s.i_ex_dest_src     = (on != 0) ? 2'd2 : 2'd0;
    bus_s.i_ex_dest_reg     = (on != 0) ? 5'd5 : 5'd0;
    bus_s.i_ex_branch_taken = 1'b0;
    bus_s.i_me_mem_req      = 1'b0;
    bus_s.i_dmem_ack        = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    idle();
    drive_s(0);

    // Reset held
    cycle(); #1;
    check("rst_adv",   32'(adv_m), 'h00);
    check("rst_flush", 32'(fl_m), 'hF);
    check("rst_req",   32'(bus.o_dmem_req), 0);
    check("rst_stall", 32'(bus.o_stall_cnt), 0);
    check("rst_fcnt",  32'(bus.o_flush_cnt), 0);
    check("rst_err",   32'(bus.o_mem_err), 0);
    cycle(); clr = 1'b0; #1;
    check("init_adv",   32'(adv_m), 'h00);
    check("init_flush", 32'(fl_m), 'hF);
    cycle(); #1;
    check("run_adv",   32'(adv_m), 'h1F);
    check("run_flush", 32'(fl_m), 'h0);

    // Load-use through rs2
    cycle(); drive(3, 1, 5, 1, 2, 5, 0, 0, 0); #1;
    check("lu2_adv",   32'(adv_m), 'h07);
    check("lu2_flush", 32'(fl_m), 'h4);
    cycle(); idle(); #1;
    check("lu2_stall", 32'(bus.o_stall_cnt), 1);
    // Load-use through rs1
    drive(7, 1, 0, 0, 2, 7, 0, 0, 0); #1;
    check("lu1_adv", 32'(adv_m), 'h07);
    cycle(); idle(); #1;
    check("lu1_stall", 32'(bus.o_stall_cnt), 2);
    // Non-hazards: r0 destination, unused source, non-load producer
    drive(0, 1, 0, 1, 2, 0, 0, 0, 0); #1;
    check("lu_r0_adv", 32'(adv_m), 'h1F);
    cycle(); drive(9, 0, 0, 0, 2, 9, 0, 0, 0); #1;
    check("lu_unused_adv", 32'(adv_m), 'h1F);
    cycle(); drive(5, 1, 5, 1, 1, 5, 0, 0, 0); #1;
    check("lu_alu_adv", 32'(adv_m), 'h1F);
    cycle(); idle(); #1;
    check("no_lu_stall", 32'(bus.o_stall_cnt), 2);

    // Branch with concurrent load-use
    drive(3, 1, 5, 1, 2, 5, 1, 0, 0); #1;
    check("br_adv",   32'(adv_m), 'h1F);
    check("br_flush", 32'(fl_m), 'hC);
    cycle(); idle(); #1;
    check("br_fcnt",  32'(bus.o_flush_cnt), 1);
    check("br_stall", 32'(bus.o_stall_cnt), 2);

    // Memory access, ack on the fourth cycle
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    check("mw0_adv",   32'(adv_m), 'h00);
    check("mw0_flush", 32'(fl_m), 'h0);
    check("mw0_req",   32'(bus.o_dmem_req), 1);
    cycle(); #1;
    check("mw1_adv", 32'(adv_m), 'h00);
    check("mw1_req", 32'(bus.o_dmem_req), 1);
    cycle(); #1;
    check("mw2_adv", 32'(adv_m), 'h00);
    check("mw2_req", 32'(bus.o_dmem_req), 1);
    cycle(); bus.i_dmem_ack = 1'b1; #1;
    check("mw_ack_adv", 32'(adv_m), 'h1F);
    check("mw_ack_req", 32'(bus.o_dmem_req), 1);
    cycle(); idle(); #1;
    check("mw_stall", 32'(bus.o_stall_cnt), 5);
    check("mw_run_req", 32'(bus.o_dmem_req), 0);
    // Zero-wait access
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
    check("zw_adv", 32'(adv_m), 'h1F);
    check("zw_req", 32'(bus.o_dmem_req), 1);
    cycle(); idle(); #1;
    check("zw_stall", 32'(bus.o_stall_cnt), 5);

    // Branch held in EX across a one-cycle wait
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
    check("mwbr_adv",   32'(adv_m), 'h00);
    check("mwbr_flush", 32'(fl_m), 'h0);
    cycle(); drive(0, 0, 0, 0, 0, 0, 1, 1, 1); #1;
    check("mwbr_ack_adv",   32'(adv_m), 'h1F);
    check("mwbr_ack_flush", 32'(fl_m), 'hC);
    cycle(); idle(); #1;
    check("mwbr_fcnt",  32'(bus.o_flush_cnt), 2);
    check("mwbr_stall", 32'(bus.o_stall_cnt), 6);

    // Watchdog: 64 unacknowledged wait cycles
    for (int i = 0; i < 64; i++) begin
      cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
      if (i == 63) begin
        check("to_pre_err", 32'(bus.o_mem_err), 0);
        check("to_pre_adv", 32'(adv_m), 'h00);
      end
    end
    cycle(); #1;
    check("to_err", 32'(bus.o_mem_err), 1);
    check("to_adv", 32'(adv_m), 'h00);
    check("to_req", 32'(bus.o_dmem_req), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
      check("halt_ack_adv", 32'(adv_m), 'h00);
    end
    cycle(); #1;
    check("halt_stall", 32'(bus.o_stall_cnt), 74);
    check("halt_err",   32'(bus.o_mem_err), 1);
    #1 clr = 1'b1; #1;
    check("hclr_adv",   32'(adv_m), 'h00);
    check("hclr_flush", 32'(fl_m), 'hF);
    check("hclr_err",   32'(bus.o_mem_err), 0);
    check("hclr_stall", 32'(bus.o_stall_cnt), 0);
    check("hclr_fcnt",  32'(bus.o_flush_cnt), 0);
    cycle(); clr = 1'b0; idle(); #1;
    check("hclr_init_flush", 32'(fl_m), 'hF);
    cycle(); #1;
    check("hclr_run_adv", 32'(adv_m), 'h1F);

    // Asynchronous clear in the middle of a memory wait
    cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    cycle(); #1;
    check("mwc_adv",   32'(adv_m), 'h00);
    check("mwc_stall", 32'(bus.o_stall_cnt), 1);
    #1 clr = 1'b1; #1;
    check("mwc_clr_adv",   32'(adv_m), 'h00);
    check("mwc_clr_flush", 32'(fl_m), 'hF);
    check("mwc_clr_req",   32'(bus.o_dmem_req), 0);
    check("mwc_clr_stall", 32'(bus.o_stall_cnt), 0);
    cycle(); clr = 1'b0; idle(); #1;
    check("mwc_init_adv",   32'(adv_m), 'h00);
    check("mwc_init_flush", 32'(fl_m), 'hF);
    cycle(); #1;
    check("mwc_run_adv",   32'(adv_m), 'h1F);
    check("mwc_run_stall", 32'(bus.o_stall_cnt), 0);

    // 4-bit counter saturation under a 20-cycle stall
    for (int i = 0; i < 20; i++) begin
      cycle(); drive_s(1); #1;
      if (i == 15) check("sat_15", 32'(bus_s.o_stall_cnt), 15);
    end
    cycle(); drive_s(0); #1;
    check("sat_hold", 32'(bus_s.o_stall_cnt), 15);
    cycle(); #1;
    check("sat_nowrap", 32'(bus_s.o_stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
